syn_i2s_dac_tx: RTL and testbench
=================================

Name: syn_i2s_dac_tx

Overview:
- Serializes stereo PCM samples (pcm_data_t from syn_audio_pkg) into an I2S bit stream for the external audio DAC.
- Sits directly downstream of the audio cache.
- Accepts one stereo sample per frame through a valid/ready handshake and holds it in a one-entry buffer.
- Generates BCLK and LRC from the system clock and shifts data MSB-first, supporting BPS_16 and BPS_32.

Parameters:
- BCLK_DIV, 4: system clocks per BCLK half-period; must be at least 2.
- PCM_DATA_W, 32: channel width, equal to syn_audio_pkg::PCM_DATA_W.

Ports:
- clk_ir  in  1  system clock.
- rst_il  in  1  asynchronous, active-low reset.
- en_i  in  1  transmit enable.
- bps_i  in  1 (bps_t)  slot width select: BPS_16 or BPS_32.
- pcm_data_i  in  2*PCM_DATA_W (pcm_data_t)  stereo sample, packed as {lchnnl, rchnnl}.
- pcm_valid_i  in  1  sample valid.
- pcm_rdy_o  out  1  buffer empty, can accept a sample.
- dac_bclk_o  out  1  I2S bit clock.
- dac_lrc_o  out  1  word select: 0 = left, 1 = right.
- dac_data_o  out  1  serial data.
- frame_done_o  out  1  one-cycle pulse when the last bit of the right slot completes.
- underflow_o  out  1  one-cycle pulse when a frame starts with the buffer empty.

Behaviour:
- Reset values: pcm_rdy_o=1, dac_bclk_o=0, dac_lrc_o=1, dac_data_o=0, frame_done_o=0, underflow_o=0. Buffer is empty, all counters are 0, FSM is in IDLE.
- Buffer handshake:
  - A transfer occurs when pcm_valid_i and pcm_rdy_o are both high on a clock edge.
  - The sample is registered into the buffer; pcm_rdy_o falls the next cycle.
  - pcm_rdy_o rises the cycle after the buffer is consumed at frame start.
  - If a transfer and a frame-start consume fall on the same edge, the consume takes the old entry and the new sample is written; pcm_rdy_o stays 0.
- BCLK generation:
  - div_cnt counts 0..BCLK_DIV-1 while in RUN.
  - At the wrap, dac_bclk_o toggles, giving a BCLK period of 2*BCLK_DIV clocks.
  - "Fall event" means the wrap with dac_bclk_o==1. dac_lrc_o and dac_data_o change only on fall events.
- Slot width W is 16 (BPS_16) or 32 (BPS_32).
  - bps_i is sampled only at frame start and held for the whole frame.
  - In BPS_16 the slot carries bits [15:0] of each channel; bits [31:16] are ignored.
- FSM:
  - IDLE: bclk held at 0, lrc at 1, data at 0. When en_i=1, go to RUN; the first fall event is a frame start.
  - RUN: bit_cnt counts 0..2W-1 over fall events.
    - bit_cnt==0 is frame start: lrc goes to 0, the buffer is loaded into the shift register, and W is latched.
    - bit_cnt==W: lrc goes to 1.
    - bit_cnt==2W-1: the following fall event ends the frame and frame_done_o pulses.
    - At frame end: if en_i=0, go to DRAIN; otherwise start the next frame.
  - DRAIN: completes the final delayed LSB bit period (one BCLK period), then returns to IDLE.
- Frame start with the buffer empty:
  - underflow_o pulses.
  - The shift register loads 0, so the frame transmits zeros.
  - The buffer stays empty.
- I2S one-bit delay:
  - The bit period starting at lrc transition k carries the LSB of the previous slot.
  - The following W-1 periods carry bits W-1..1 of the current slot.
  - Bit 0 appears in the first period after the next lrc transition.
  - The first frame after IDLE carries 0 in its first bit period.
- en_i deassertion mid-frame does not truncate the frame. en_i reasserted during DRAIN is ignored until IDLE is reached.
- Reset mid-frame returns all state to reset values immediately (asynchronous). Any buffered sample is discarded.
- Output registers are driven directly from flops (no combinational outputs), except pcm_rdy_o, which equals !buf_vld.

Test Plan:
- BCLK_DIV=2, BPS_32, single sample L=0xA5A5_0001, R=0x8000_00FF, en_i=1 -> BCLK period 4 clocks; lrc low for 32 BCLKs then high for 32. Serial is 0, then L[31:1]; then L[0]=1 followed by R[31:1]; then R[0]=1 at the start of the next frame. frame_done_o pulses once per 64 BCLKs.
- BPS_16, L=0x1234_BEEF, R=0xFFFF_0001 -> 16-bit slots carry 0xBEEF and 0x0001; the upper halves never appear. Frame is 32 BCLKs.
- Buffer empty at frame start -> underflow_o pulses exactly once; frame data all 0. A sample presented mid-frame is accepted (pcm_rdy_o=0 next cycle) and transmitted in the next frame.
- Continuous valid with a new sample each frame -> exactly one accept per frame and no underflow. The simultaneous accept/consume edge keeps pcm_rdy_o=0.
- bps_i toggled mid-frame from BPS_32 to BPS_16 -> current frame completes with 32-bit slots; the next frame uses 16-bit slots.
- Deassert en_i mid-frame -> frame completes, frame_done_o pulses, one DRAIN BCLK period follows, then IDLE with lrc=1, bclk=0. Assert rst_il low mid-frame -> all outputs reach reset values with no clock edge required.

Source files
------------

// File: rtl/syn_i2s_dac_tx.sv
// -----------------------------------------------------------------------------
// syn_audio_pkg / syn_i2s_dac_tx
//
// I2S transmitter for the external audio DAC. One stereo PCM sample per frame
// is taken from the audio cache through a valid/ready handshake into a
// one-entry buffer. The sample is serialized MSB-first with the standard I2S
// one-bit delay, using 16- or 32-bit slots.
//
// Ports:
//   clk_ir        system clock
//   rst_il        asynchronous active-low reset
//   en_i          transmit enable (sampled at frame boundaries)
//   bps_i         slot width select, BPS_16 / BPS_32 (sampled at frame start)
//   pcm_data_i    stereo sample {lchnnl, rchnnl}
//   pcm_valid_i   sample valid
//   pcm_rdy_o     buffer empty, sample can be accepted
//   dac_bclk_o    I2S bit clock, period 2*BCLK_DIV system clocks
//   dac_lrc_o     word select, 0 = left, 1 = right
//   dac_data_o    serial data, changes on BCLK falling events only
//   frame_done_o  one-cycle pulse when the last right-slot bit completes
//   underflow_o   one-cycle pulse when a frame starts with the buffer empty
// -----------------------------------------------------------------------------

package syn_audio_pkg;
    localparam int PCM_DATA_W = 32;

    typedef enum logic {
        BPS_16 = 1'b0,
        BPS_32 = 1'b1
    } bps_t;

    typedef struct packed {
        logic [PCM_DATA_W-1:0] lchnnl;
        logic [PCM_DATA_W-1:0] rchnnl;
    } pcm_data_t;
endpackage

module syn_i2s_dac_tx #(
    parameter int BCLK_DIV   = 4,
    parameter int PCM_DATA_W = syn_audio_pkg::PCM_DATA_W
) (
    input  logic                     clk_ir,
    input  logic                     rst_il,
    input  logic                     en_i,
    input  syn_audio_pkg::bps_t      bps_i,
    input  syn_audio_pkg::pcm_data_t pcm_data_i,
    input  logic                     pcm_valid_i,
    output logic                     pcm_rdy_o,
    output logic                     dac_bclk_o,
    output logic                     dac_lrc_o,
    output logic                     dac_data_o,
    output logic                     frame_done_o,
    output logic                     underflow_o
);

    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam int SR_W  = 2 * PCM_DATA_W;
    localparam int CNT_W = $clog2(SR_W);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_32  = CNT_W'(PCM_DATA_W);
    localparam logic [CNT_W-1:0] LAST_32  = CNT_W'(SR_W - 1);
    localparam logic [CNT_W-1:0] HALF_16  = CNT_W'(16);
    localparam logic [CNT_W-1:0] LAST_16  = CNT_W'(31);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Arrange both slots MSB-first in one shift word. In 16-bit mode only the
    // low halves of each channel are sent; the unused tail is zero.
    function automatic logic [SR_W-1:0] pack_slots(
        input syn_audio_pkg::pcm_data_t d,
        input logic                     wide
    );
        if (wide) begin
            return {d.lchnnl, d.rchnnl};
        end else begin
            return {d.lchnnl[15:0], d.rchnnl[15:0], {(SR_W-32){1'b0}}};
        end
    endfunction

    logic [1:0]                state;
    logic [DIV_W-1:0]          div_cnt;
    logic [CNT_W-1:0]          bit_cnt;
    logic                      bclk;
    logic                      lrc;
    logic                      sdata;
    logic                      frame_done;
    logic                      underflow;
    logic                      buf_vld;
    logic                      dly_bit;
    logic                      w32;
    logic                      frame_act;
    syn_audio_pkg::pcm_data_t  buf_data;
    logic [SR_W-1:0]           shreg;

    logic                      div_wrap;
    logic                      fall_evt;
    logic                      run_fall;
    logic                      frame_start;
    logic                      frame_end;
    logic                      accept;
    logic                      consume;
    logic [SR_W-1:0]           load_word;
    logic [CNT_W-1:0]          slot_half;
    logic [CNT_W-1:0]          slot_last;

    assign div_wrap  = (div_cnt == DIV_LAST);
    // bclk is held low in IDLE, so a fall event can only occur in RUN/DRAIN.
    assign fall_evt  = div_wrap && bclk;
    assign run_fall  = (state == ST_RUN) && fall_evt;

    // bit_cnt==0 on a fall event is the boundary between frames. frame_act
    // tells a real frame end apart from the very first boundary after IDLE.
    assign frame_end   = run_fall && (bit_cnt == '0) && frame_act;
    assign frame_start = run_fall && (bit_cnt == '0) && (!frame_act || en_i);

    assign accept    = pcm_valid_i && !buf_vld;
    assign consume   = frame_start && buf_vld;
    assign load_word = buf_vld ? pack_slots(buf_data, bps_i == syn_audio_pkg::BPS_32) : '0;
    assign slot_half = w32 ? HALF_32 : HALF_16;
    assign slot_last = w32 ? LAST_32 : LAST_16;

    // Control and output flops
    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            state      <= ST_IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            bclk       <= 1'b0;
            lrc        <= 1'b1;
            sdata      <= 1'b0;
            frame_done <= 1'b0;
            underflow  <= 1'b0;
            buf_vld    <= 1'b0;
            dly_bit    <= 1'b0;
            w32        <= 1'b0;
            frame_act  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            underflow  <= 1'b0;
            // A consume always takes the old entry; a same-edge accept refills.
            buf_vld    <= (buf_vld && !consume) || accept;

            case (state)
                ST_IDLE: begin
                    div_cnt   <= '0;
                    bit_cnt   <= '0;
                    bclk      <= 1'b0;
                    lrc       <= 1'b1;
                    sdata     <= 1'b0;
                    dly_bit   <= 1'b0;
                    frame_act <= 1'b0;
                    if (en_i) begin
                        state <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
                    if (div_wrap) begin
                        bclk <= ~bclk;
                    end
                    if (fall_evt) begin
                        // dly_bit realises the I2S one-bit delay: every period
                        // shows the bit that left the shift register one
                        // period earlier.
                        sdata   <= dly_bit;
                        dly_bit <= shreg[SR_W-1];
                        if (frame_end) begin
                            frame_done <= 1'b1;
                        end
                        if (frame_start) begin
                            frame_act <= 1'b1;
                            lrc       <= 1'b0;
                            w32       <= (bps_i == syn_audio_pkg::BPS_32);
                            bit_cnt   <= CNT_W'(1);
                            dly_bit   <= load_word[SR_W-1];
                            underflow <= !buf_vld;
                        end else if (frame_end) begin
                            // Enable dropped: the right LSB just went out and
                            // still needs its full bit period in DRAIN.
                            state     <= ST_DRAIN;
                            frame_act <= 1'b0;
                        end else begin
                            if (bit_cnt == slot_half) begin
                                lrc <= 1'b1;
                            end
                            bit_cnt <= (bit_cnt == slot_last) ? '0 : bit_cnt + CNT_W'(1);
                        end
                    end
                end

                ST_DRAIN: begin
                    div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
                    if (div_wrap) begin
                        bclk <= ~bclk;
                    end
                    if (fall_evt) begin
                        state   <= ST_IDLE;
                        sdata   <= 1'b0;
                        dly_bit <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sample buffer and shift register; contents are qualified by buf_vld and
    // frame_start, so they carry no reset.
    always_ff @(posedge clk_ir) begin
        if (accept) begin
            buf_data <= pcm_data_i;
        end
        if (frame_start) begin
            shreg <= load_word << 1;
        end else if (run_fall) begin
            shreg <= shreg << 1;
        end
    end

    assign pcm_rdy_o    = !buf_vld;
    assign dac_bclk_o   = bclk;
    assign dac_lrc_o    = lrc;
    assign dac_data_o   = sdata;
    assign frame_done_o = frame_done;
    assign underflow_o  = underflow;

endmodule

// File: tb/tb_syn_i2s_dac_tx.sv
// -----------------------------------------------------------------------------
// Testbench for syn_i2s_dac_tx. A frame-level reference model predicts BCLK,
// word select, serial data, frame_done, underflow and ready every clock from
// the I2S framing rules; directed and randomized steps drive the DUT.
// -----------------------------------------------------------------------------
module tb_syn_i2s_dac_tx;
    import syn_audio_pkg::*;

    localparam int DIV = 2;

    logic      clk = 1'b0;
    logic      rst_n;
    logic      en;
    bps_t      bps;
    pcm_data_t pcm_data;
    logic      pcm_valid;
    logic      rdy;
    logic      bclk;
    logic      lrc;
    logic      sdata;
    logic      fd;
    logic      uf;

    always #5 clk = ~clk;

    syn_i2s_dac_tx #(
        .BCLK_DIV   (DIV),
        .PCM_DATA_W (32)
    ) dut (
        .clk_ir       (clk),
        .rst_il       (rst_n),
        .en_i         (en),
        .bps_i        (bps),
        .pcm_data_i   (pcm_data),
        .pcm_valid_i  (pcm_valid),
        .pcm_rdy_o    (rdy),
        .dac_bclk_o   (bclk),
        .dac_lrc_o    (lrc),
        .dac_data_o   (sdata),
        .frame_done_o (fd),
        .underflow_o  (uf)
    );

    // Reference model state
    int          m_phase;   // 0 idle, 1 run, 2 drain
    int          m_t;       // clock edges since entering run / drain
    int          m_pidx;    // next bit period index within the frame
    int          m_W;       // slot width of the current frame
    logic        m_active;
    logic        m_prev;    // right LSB of the previous frame
    logic [31:0] m_L;
    logic [31:0] m_R;
    logic        m_full;
    pcm_data_t   m_buf;
    logic        exp_bclk;
    logic        exp_lrc;
    logic        exp_data;
    logic        last_acc;

    int n_tests;
    int n_fail;

    task automatic check(input string tag, input logic obs, input logic expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic check_outputs(input logic efd, input logic euf);
        check("bclk", bclk, exp_bclk);
        check("lrc", lrc, exp_lrc);
        check("data", sdata, exp_data);
        check("frame_done", fd, efd);
        check("underflow", uf, euf);
        check("rdy", rdy, !m_full);
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_t      = 0;
        m_pidx   = 0;
        m_W      = 32;
        m_active = 1'b0;
        m_prev   = 1'b0;
        m_L      = '0;
        m_R      = '0;
        m_full   = 1'b0;
        exp_bclk = 1'b0;
        exp_lrc  = 1'b1;
        exp_data = 1'b0;
        last_acc = 1'b0;
    endtask

    // I2S framing: period 0 carries the previous right LSB, periods 1..W-1
    // carry L[W-1..1], period W carries L[0] with lrc high, then R[W-1..1].
    function automatic logic [1:0] period_bits(input int k);
        logic [31:0] t;
        if (k == 0) begin
            return {1'b0, m_prev};
        end else if (k < m_W) begin
            t = m_L >> (m_W - k);
            return {1'b0, t[0]};
        end else if (k == m_W) begin
            return {1'b1, m_L[0]};
        end else begin
            t = m_R >> (2 * m_W - k);
            return {1'b1, t[0]};
        end
    endfunction

    task automatic tick();
        logic      acc;
        logic      cons;
        logic      efd;
        logic      euf;
        logic      en_in;
        bps_t      b_in;
        pcm_data_t d_in;
        en_in = en;
        b_in  = bps;
        d_in  = pcm_data;
        acc   = pcm_valid && !m_full;
        @(posedge clk);
        #1;
        cons = 1'b0;
        efd  = 1'b0;
        euf  = 1'b0;
        case (m_phase)
            0: begin
                exp_bclk = 1'b0;
                exp_lrc  = 1'b1;
                exp_data = 1'b0;
                if (en_in) begin
                    m_phase  = 1;
                    m_t      = 0;
                    m_active = 1'b0;
                end
            end
            1: begin
                m_t++;
                exp_bclk = ((m_t / DIV) % 2) == 1;
                if (m_t % (2 * DIV) == 0) begin
                    if (!m_active || m_pidx == 2 * m_W) begin
                        if (m_active) efd = 1'b1;
                        if (m_active && !en_in) begin
                            m_phase  = 2;
                            m_t      = 0;
                            m_active = 1'b0;
                            exp_data = m_R[0];
                        end else begin
                            m_prev   = m_active ? m_R[0] : 1'b0;
                            euf      = !m_full;
                            cons     = m_full;
                            m_L      = m_full ? m_buf.lchnnl : 32'd0;
                            m_R      = m_full ? m_buf.rchnnl : 32'd0;
                            m_W      = (b_in == BPS_32) ? 32 : 16;
                            m_active = 1'b1;
                            {exp_lrc, exp_data} = period_bits(0);
                            m_pidx   = 1;
                        end
                    end else begin
                        {exp_lrc, exp_data} = period_bits(m_pidx);
                        m_pidx++;
                    end
                end
            end
            default: begin
                m_t++;
                exp_bclk = ((m_t / DIV) % 2) == 1;
                if (m_t == 2 * DIV) begin
                    m_phase  = 0;
                    exp_data = 1'b0;
                end
            end
        endcase
        m_full = (m_full && !cons) || acc;
        if (acc) m_buf = d_in;
        last_acc = acc;
        check_outputs(efd, euf);
    endtask

    // mode 0: single sample, valid drops after accept
    // mode 1: continuous valid, new sample after each accept
    // mode 2: random sample arrivals and random bps changes
    task automatic run_cycles(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            if (mode == 2) begin
                if (!pcm_valid && $urandom_range(0, 39) == 0) begin
                    pcm_valid = 1'b1;
                    pcm_data  = {$urandom(), $urandom()};
                end
                if ($urandom_range(0, 299) == 0) begin
                    bps = (bps == BPS_32) ? BPS_16 : BPS_32;
                end
            end
            tick();
            if (last_acc) begin
                if (mode == 1) pcm_data = {$urandom(), $urandom()};
                else           pcm_valid = 1'b0;
            end
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        en        = 1'b0;
        bps       = BPS_32;
        pcm_valid = 1'b0;
        pcm_data  = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs(1'b0, 1'b0);
        rst_n = 1'b1;

        // 32-bit slots with a known sample, then an underflow frame
        pcm_data.lchnnl = 32'hA5A5_0001;
        pcm_data.rchnnl = 32'h8000_00FF;
        pcm_valid       = 1'b1;
        en              = 1'b1;
        run_cycles(600, 0);

        // 16-bit slots, upper halves must never appear
        bps             = BPS_16;
        pcm_data.lchnnl = 32'h1234_BEEF;
        pcm_data.rchnnl = 32'hFFFF_0001;
        pcm_valid       = 1'b1;
        run_cycles(400, 0);

        // Empty-buffer frames, then a sample arriving mid-frame
        run_cycles(150, 0);
        pcm_data  = {$urandom(), $urandom()};
        pcm_valid = 1'b1;
        run_cycles(300, 0);

        // Continuous valid, then a 32->16 width change mid-stream
        bps       = BPS_32;
        pcm_data  = {$urandom(), $urandom()};
        pcm_valid = 1'b1;
        run_cycles(700, 1);
        bps = BPS_16;
        run_cycles(500, 1);
        pcm_valid = 1'b0;

        // Randomized arrivals and widths
        run_cycles(3000, 2);

        // Enable dropped mid-frame: frame completes, drain, idle
        pcm_valid = 1'b0;
        run_cycles(120, 0);
        en = 1'b0;
        run_cycles(400, 0);

        // Re-enable with a buffered sample, then asynchronous reset mid-frame
        en        = 1'b1;
        bps       = BPS_32;
        pcm_data  = {$urandom(), $urandom()};
        pcm_valid = 1'b1;
        run_cycles(150, 0);
        pcm_data  = {$urandom(), $urandom()};
        pcm_valid = 1'b1;
        run_cycles(5, 0);
        rst_n = 1'b0;
        #2;
        model_reset();
        check_outputs(1'b0, 1'b0);
        pcm_valid = 1'b0;
        en        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_outputs(1'b0, 1'b0);

        // Restart after reset: the discarded sample must not reappear
        en = 1'b1;
        run_cycles(300, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
